func_unit: RTL and testbench
============================

Name: func_unit

Overview:
- Processing-element functional unit. Sits directly downstream of the join/merge handshake stage and consumes its dout_1/dout_2/cout/dout_v bundle.
- Applies a configured ALU operation, multiplex or accumulation, then registers the result behind a 1-deep elastic output register that feeds the PE output ports.
- Produces a data result plus a 1-bit control result; the control result can drive the control input of a downstream join stage.

Parameters:
DATA_WIDTH, 32, width of data operands and result
CNT_WIDTH, 16, width of accumulation iteration counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
din_1  input  DATA_WIDTH  operand A (join stage dout_1)
din_2  input  DATA_WIDTH  operand B (join stage dout_2)
cin  input  1  control bit (join stage cout)
din_v  input  1  operand bundle valid
din_r  output  1  operand bundle ready
dout  output  DATA_WIDTH  registered result
cout  output  1  registered control result
dout_v  output  1  result valid
dout_r  input  1  result ready
alu_sel  input  4  operation select; static while running
fu_mode  input  2  00 ALU, 01 accumulate, 10 mux, 11 same as 00
initial_data  input  DATA_WIDTH  accumulator initial value
iterations  input  CNT_WIDTH  inputs per accumulated result; 0 treated as 1
clr  input  1  synchronous clear pulse

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, cout=0, dout_v=0.
  - acc=initial_data is not reset-safe, so acc is reset to 0 and acc_init flag=1; state=LOAD, cnt=0.
- Handshake:
  - din_r = !dout_v | dout_r.
  - Input transfer when din_v & din_r.
  - Output transfer when dout_v & dout_r.
  - No combinational path from din_v to dout_v.
  - Latency 1 cycle; throughput 1 per cycle with dout_r held high.
- Output register:
  - Loaded on an input transfer that produces a result: dout_v<=1.
  - Otherwise, on an output transfer, dout_v<=0.
  - dout/cout hold while dout_v=1 and dout_r=0.
- ALU ops (alu_sel):
  - 0 ADD, 1 SUB (A-B), 2 MUL (low DATA_WIDTH bits).
  - 3 SLL, 4 SRL, 5 SRA; shift amount is B[$clog2(DATA_WIDTH)-1:0].
  - 6 AND, 7 OR, 8 XOR.
  - 9 EQ, 10 LT signed, 11 GT signed; result is 0/1 and cout equals the result.
  - 12-15 give result 0.
  - cout=0 for ops 0-8 and 12-15.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- Mode 00 ALU: every input transfer loads dout=ALU(din_1,din_2).
- Mode 10 mux:
  - dout = cin ? din_2 : din_1; cout = cin.
  - Matches merge semantics: cin=1 means operand A is absent.
- Mode 01 accumulate, FSM LOAD/RUN:
  - Operand A is the accumulator.
  - LOAD: on input transfer, acc_next=ALU(initial_data,din_2), cnt<=1, go to RUN.
  - RUN: on input transfer, acc_next=ALU(acc,din_2), cnt<=cnt+1.
  - When the transfer makes cnt equal to max(iterations,1):
    - dout<=acc_next, dout_v<=1, cnt<=0, state<=LOAD.
  - Otherwise acc<=acc_next and no output is produced.
  - iterations=1 (or 0) emits ALU(initial_data,din_2) on every input.
  - Intermediate accumulations still require din_r (output reg free), for a uniform handshake.
- clr=1:
  - Next edge: dout_v<=0, state<=LOAD, cnt<=0, acc<=0.
  - An input transfer in the same cycle is discarded.
  - clr has priority over all other updates.
- Async reset mid-accumulation: partial sum lost; restart from LOAD.
- Counter must not overflow: max count is 2^CNT_WIDTH-1, and it is compared before incrementing.

Decomposition:
- Shared package cgra_pkg holds:
  - alu_op_t enum (4-bit, codes above)
  - fu_mode_t enum (FU_ALU, FU_ACC, FU_MUX)
  - fu_state_t (LOAD, RUN)
- Sub-module alu: purely combinational.
  - Ports a, b, sel, result, cmp.
  - Parameterised by DATA_WIDTH.
  - Instantiated once, with a operand muxed between din_1, initial_data and acc.

Test Plan:
1. Mode 00, ADD, din_1=0xFFFFFFFF, din_2=2, dout_r=1 -> next cycle dout=1, dout_v=1, cout=0.
2. Mode 00, LT, din_1=-3, din_2=5, dout_r=0 for 3 cycles -> dout=1, cout=1 held stable; din_r=0 until dout_r rises; then din_r=1.
3. Mode 01, ADD, initial_data=10, iterations=4, din_2=1,2,3,4 back-to-back -> single output dout=20 after the 4th transfer; dout_v=0 before it; next group restarts from 10.
4. Mode 01, iterations=0, MUL, initial_data=3, din_2=7 -> dout=21 on every input.
5. Mode 10, cin=1, din_1=0xAA, din_2=0x55 -> dout=0x55, cout=1; with cin=0 -> dout=0xAA, cout=0.
6. Mode 01, iterations=4, two inputs accepted, then clr pulse, then four inputs of 1 with initial_data=0 -> dout=4 (pre-clr sum discarded). Repeat with rst_n low mid-group -> all outputs 0 asynchronously, same restart result.

Source files
------------

// File: rtl/func_unit_pkg.sv
// Shared CGRA types: ALU opcodes, functional-unit modes and accumulator FSM states.
package cgra_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_SLL = 4'd3,
    OP_SRL = 4'd4,
    OP_SRA = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8,
    OP_EQ  = 4'd9,
    OP_LT  = 4'd10,
    OP_GT  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'b00,
    FU_ACC = 2'b01,
    FU_MUX = 2'b10
  } fu_mode_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } fu_state_t;

endpackage

// File: rtl/func_unit_if.sv
// Operand/result handshake bundle between the join stage, the functional unit and its consumer.
interface func_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] din_1;
  logic [DATA_WIDTH-1:0] din_2;
  logic                  cin;
  logic                  din_v;
  logic                  din_r;
  logic [DATA_WIDTH-1:0] dout;
  logic                  cout;
  logic                  dout_v;
  logic                  dout_r;

  modport master (
    output din_1, din_2, cin, din_v, dout_r,
    input  din_r, dout, cout, dout_v
  );

  modport slave (
    input  din_1, din_2, cin, din_v, dout_r,
    output din_r, dout, cout, dout_v
  );
endinterface

// File: rtl/func_unit_alu.sv
// Combinational ALU; comparison ops return 0/1 on result and mirror it on cmp.
module alu
  import cgra_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            sel,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cmp
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    cmp    = 1'b0;
    case (sel)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_SLL: result = a << shamt;
      OP_SRL: result = a >> shamt;
      OP_SRA: result = $unsigned($signed(a) >>> shamt);
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_EQ: begin
        cmp    = (a == b);
        result = {{(DATA_WIDTH-1){1'b0}}, cmp};
      end
      OP_LT: begin
        cmp    = ($signed(a) < $signed(b));
        result = {{(DATA_WIDTH-1){1'b0}}, cmp};
      end
      OP_GT: begin
        cmp    = ($signed(a) > $signed(b));
        result = {{(DATA_WIDTH-1){1'b0}}, cmp};
      end
      default: begin
        result = '0;
        cmp    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/func_unit.sv
// PE functional unit: ALU / accumulate / mux datapath behind a 1-deep elastic output register.
module func_unit
  import cgra_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  func_unit_if.slave            bus,
  input  logic [3:0]            alu_sel,
  input  logic [1:0]            fu_mode,
  input  logic [DATA_WIDTH-1:0] initial_data,
  input  logic [CNT_WIDTH-1:0]  iterations,
  input  logic                  clr
);

  fu_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  cout_q, cout_d;
  logic                  dout_v_q, dout_v_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  in_xfer;
  logic                  is_acc;
  logic                  is_mux;
  logic                  last;
  logic                  produce;
  logic [CNT_WIDTH-1:0]  last_cnt;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_cmp;

  assign bus.din_r  = !dout_v_q || bus.dout_r;
  assign bus.dout   = dout_q;
  assign bus.cout   = cout_q;
  assign bus.dout_v = dout_v_q;

  assign in_xfer = bus.din_v && bus.din_r;
  assign is_acc  = (fu_mode == FU_ACC);
  assign is_mux  = (fu_mode == FU_MUX);

  // Compare against max(iterations,1)-1 before incrementing so cnt never exceeds 2^CNT_WIDTH-1.
  assign last_cnt = (iterations == '0) ? '0 : iterations - CNT_WIDTH'(1);
  assign last     = (cnt_q == last_cnt);

  assign alu_a = !is_acc          ? bus.din_1    :
                 (state_q == LOAD) ? initial_data : acc_q;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (alu_a),
    .b      (bus.din_2),
    .sel    (alu_sel),
    .result (alu_res),
    .cmp    (alu_cmp)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    cout_d   = cout_q;
    dout_v_d = dout_v_q;
    cnt_d    = cnt_q;
    produce  = 1'b0;

    if (clr) begin
      dout_v_d = 1'b0;
      state_d  = LOAD;
      cnt_d    = '0;
      acc_d    = '0;
    end else begin
      if (in_xfer) begin
        if (is_acc) begin
          if (last) begin
            produce = 1'b1;
            dout_d  = alu_res;
            cout_d  = alu_cmp;
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            acc_d   = alu_res;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = RUN;
          end
        end else if (is_mux) begin
          produce = 1'b1;
          dout_d  = bus.cin ? bus.din_2 : bus.din_1;
          cout_d  = bus.cin;
        end else begin
          produce = 1'b1;
          dout_d  = alu_res;
          cout_d  = alu_cmp;
        end
      end

      if (produce) begin
        dout_v_d = 1'b1;
      end else if (dout_v_q && bus.dout_r) begin
        dout_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      acc_q    <= '0;
      dout_q   <= '0;
      cout_q   <= 1'b0;
      dout_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      cout_q   <= cout_d;
      dout_v_q <= dout_v_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_func_unit.sv
// Scoreboard bench for func_unit: directed scenarios plus randomized traffic against a reference model.
module tb_func_unit;
  import cgra_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    alu_sel;
  logic [1:0]    fu_mode;
  logic [DW-1:0] initial_data;
  logic [CW-1:0] iterations;
  logic          clr;

  always #5 clk = ~clk;

  func_unit_if #(.DATA_WIDTH(DW)) bif();

  func_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bif.slave),
    .alu_sel      (alu_sel),
    .fu_mode      (fu_mode),
    .initial_data (initial_data),
    .iterations   (iterations),
    .clr          (clr)
  );

  int          total = 0;
  int          bad   = 0;
  bit          use_model = 1'b0;
  bit          done = 1'b0;
  exp_t        exp_q[$];
  int unsigned m_cnt = 0;
  logic [DW-1:0] m_acc = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, output logic [DW-1:0] r,
                                  output logic c);
    int unsigned sh;
    sh = b % DW;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a * b;
      4'd3:  r = a << sh;
      4'd4:  r = a >> sh;
      4'd5:  r = $signed(a) >>> sh;
      4'd6:  r = a & b;
      4'd7:  r = a | b;
      4'd8:  r = a ^ b;
      4'd9:  r = (a == b) ? 1 : 0;
      4'd10: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd11: r = ($signed(a) > $signed(b)) ? 1 : 0;
      default: r = 0;
    endcase
    c = (op >= 4'd9 && op <= 4'd11) ? r[0] : 1'b0;
  endfunction

  // Reference model: a group of max(iterations,1) inputs folds into one result.
  task automatic model_accept(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic c);
    exp_t e;
    logic [DW-1:0] r;
    logic rc;
    int unsigned tgt;
    if (!use_model) return;
    if (fu_mode == 2'b01) begin
      tgt = (iterations == 0) ? 1 : int'(iterations);
      ref_alu(alu_sel, (m_cnt == 0) ? initial_data : m_acc, d2, r, rc);
      m_cnt++;
      if (m_cnt == tgt) begin
        e.d = r; e.c = rc;
        exp_q.push_back(e);
        m_cnt = 0;
      end else begin
        m_acc = r;
      end
    end else if (fu_mode == 2'b10) begin
      e.d = c ? d2 : d1; e.c = c;
      exp_q.push_back(e);
    end else begin
      ref_alu(alu_sel, d1, d2, r, rc);
      e.d = r; e.c = rc;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input bit c, input bit rdy, input bit cl, output bit acc);
    @(negedge clk);
    bif.din_v  = v;
    bif.din_1  = d1;
    bif.din_2  = d2;
    bif.cin    = c;
    bif.dout_r = rdy;
    clr        = cl;
    #1;
    acc = v && bif.din_r && !cl && rst_n;
    if (acc) model_accept(d1, d2, c);
    if (cl) begin
      m_cnt = 0;
      m_acc = '0;
    end
  endtask

  task automatic send(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input bit c, input bit rdy);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cycle(1'b1, d1, d2, c, rdy, 1'b0, acc);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got not-accepted want accepted at %0t", $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic c);
    exp_t e;
    e.d = d; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0 && !bif.dout_v) break;
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bif.din_v = 1'b0;
    clr = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_acc = '0;
    #1;
    check("rst_dout", bif.dout, '0);
    check("rst_cout", {31'd0, bif.cout}, 32'd0);
    check("rst_dout_v", {31'd0, bif.dout_v}, 32'd0);
    check("rst_din_r", {31'd0, bif.din_r}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return DW'($urandom_range(0, 40));
      default: return DW'($urandom);
    endcase
  endfunction

  // Monitor: pops the scoreboard on each output transfer, checks hold while stalled.
  initial begin : monitor
    bit            stall = 1'b0;
    logic [DW-1:0] hd;
    logic          hc;
    exp_t          e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_v", {31'd0, bif.dout_v}, 32'd1);
          check("hold_dout", bif.dout, hd);
          check("hold_cout", {31'd0, bif.cout}, {31'd0, hc});
        end
        if (bif.dout_v) begin
          if (bif.dout_r) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_out: got %h want none at %0t", bif.dout, $time);
            end else begin
              e = exp_q.pop_front();
              check("dout", bif.dout, e.d);
              check("cout", {31'd0, bif.cout}, {31'd0, e.c});
            end
          end else if (clr && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
          end
        end
        stall = bif.dout_v && !bif.dout_r && !clr;
        hd = bif.dout;
        hc = bif.cout;
      end
    end
  end

  initial begin : driver
    bit acc;
    rst_n = 1'b0;
    clr = 1'b0;
    bif.din_v = 1'b0;
    bif.din_1 = '0;
    bif.din_2 = '0;
    bif.cin = 1'b0;
    bif.dout_r = 1'b0;
    alu_sel = 4'd0;
    fu_mode = 2'b00;
    initial_data = '0;
    iterations = '0;
    #12;
    check("reset_dout", bif.dout, '0);
    check("reset_cout", {31'd0, bif.cout}, 32'd0);
    check("reset_dout_v", {31'd0, bif.dout_v}, 32'd0);
    check("reset_din_r", {31'd0, bif.din_r}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD wraps
    fu_mode = 2'b00; alu_sel = 4'd0;
    send(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    push_exp(32'd1, 1'b0);
    drain();

    // LT with output stalled for three cycles
    alu_sel = 4'd10;
    send(-32'sd3, 32'd5, 1'b0, 1'b0);
    push_exp(32'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      check("stall_din_r", {31'd0, bif.din_r}, 32'd0);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    check("release_din_r", {31'd0, bif.din_r}, 32'd1);
    drain();

    // Accumulate 10+1+2+3+4, then a second group restarting from 10
    fu_mode = 2'b01; alu_sel = 4'd0; initial_data = 32'd10; iterations = 16'd4;
    for (int k = 1; k <= 4; k++) begin
      send(32'd0, DW'(k), 1'b0, 1'b1);
      if (k > 1) check("acc_no_out", {31'd0, bif.dout_v}, 32'd0);
    end
    push_exp(32'd20, 1'b0);
    for (int k = 0; k < 4; k++) send(32'd0, 32'd1, 1'b0, 1'b1);
    push_exp(32'd14, 1'b0);
    drain();

    // iterations=0 behaves as 1
    iterations = 16'd0; alu_sel = 4'd2; initial_data = 32'd3;
    for (int k = 0; k < 3; k++) begin
      send(32'd0, 32'd7, 1'b0, 1'b1);
      push_exp(32'd21, 1'b0);
    end
    drain();

    // Mux
    fu_mode = 2'b10;
    send(32'hAA, 32'h55, 1'b1, 1'b1);
    push_exp(32'h55, 1'b1);
    send(32'hAA, 32'h55, 1'b0, 1'b1);
    push_exp(32'hAA, 1'b0);
    drain();

    // clr mid-group discards the partial sum
    fu_mode = 2'b01; alu_sel = 4'd0; initial_data = 32'd0; iterations = 16'd4;
    send(32'd0, 32'd5, 1'b0, 1'b1);
    send(32'd0, 32'd6, 1'b0, 1'b1);
    cycle(1'b1, 32'd0, 32'd9, 1'b0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 4; k++) send(32'd0, 32'd1, 1'b0, 1'b1);
    push_exp(32'd4, 1'b0);
    drain();

    // async reset mid-group
    send(32'd0, 32'd5, 1'b0, 1'b1);
    send(32'd0, 32'd6, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) send(32'd0, 32'd1, 1'b0, 1'b1);
    push_exp(32'd4, 1'b0);
    drain();

    // Randomized traffic against the reference model
    use_model = 1'b1;
    m_cnt = 0;
    m_acc = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
        alu_sel = 4'($urandom_range(0, 15));
        fu_mode = 2'($urandom_range(0, 3));
        initial_data = rand_data();
        case ($urandom_range(0, 5))
          0: iterations = 16'd0;
          1: iterations = 16'd1;
          2: iterations = 16'd2;
          3: iterations = 16'd3;
          4: iterations = 16'd5;
          default: iterations = 16'd7;
        endcase
      end
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 3) != 0, rand_data(), rand_data(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
    end
    drain();

    done = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
